// File: rtl/bin2bcd_seq_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter.
//   state_t         : FSM state encoding (IDLE / SHIFT / DONE), 2 bits
//   DEF_BIN_LEN     : default binary operand width
//   DEF_BCD_LEN     : default BCD result width (4 bits per digit)
//   min_bcd_digits  : decimal digits needed to hold 2^bin_len - 1
package bin2bcd_seq_pkg;

  localparam int unsigned DEF_BIN_LEN = 8;
  localparam int unsigned DEF_BCD_LEN = 12;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

  // Digit count of 2^b - 1 equals floor(b * log10(2)) + 1, because 2^b is
  // never an exact power of ten. log10(2) is held as a 12-digit fixed-point
  // fraction so the result is exact for any practical width.
  function automatic int unsigned min_bcd_digits(input int unsigned bin_len);
    longint unsigned scaled;
    scaled = 64'(bin_len) * 64'd301029995664;
    return 32'(scaled / 64'd1000000000000) + 32'd1;
  endfunction

endpackage

// File: rtl/bin2bcd_seq_dd_iter.sv
// One combinational double-dabble step.
//   work_in  : work register {BCD digits, binary remainder}
//   work_out : every BCD digit > 4 incremented by 3, then whole word << 1
// The MSB shifted out is discarded.
module dd_iter
  import bin2bcd_seq_pkg::*;
#(
  parameter int unsigned BIN_LEN = DEF_BIN_LEN,
  parameter int unsigned BCD_LEN = DEF_BCD_LEN
) (
  input  logic [BIN_LEN+BCD_LEN-1:0] work_in,
  output logic [BIN_LEN+BCD_LEN-1:0] work_out
);

  localparam int unsigned WORK_LEN = BIN_LEN + BCD_LEN;
  localparam int unsigned N_DIGITS = BCD_LEN / 4;

  logic [WORK_LEN-1:0] adj;

  always_comb begin
    adj = work_in;
    for (int unsigned d = 0; d < N_DIGITS; d++) begin
      if (adj[BIN_LEN + 4*d +: 4] > 4'd4) begin
        adj[BIN_LEN + 4*d +: 4] = adj[BIN_LEN + 4*d +: 4] + 4'd3;
      end
    end
    work_out = {adj[WORK_LEN-2:0], 1'b0};
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble, one bit per cycle).
//   clk, rst   : clock, synchronous active-high reset
//   in_valid   : bin_in valid; accepted when in_ready is high
//   in_ready   : high in IDLE only
//   bin_in     : unsigned binary operand
//   out_valid  : bcd_out holds a finished result (DONE)
//   out_ready  : consumer takes the result; honoured in DONE only
//   bcd_out    : packed BCD result, digit 0 in bits [3:0]
//   busy       : conversion in progress (SHIFT)
// Result appears BIN_LEN cycles after acceptance; no operand queueing.
module bin2bcd_seq
  import bin2bcd_seq_pkg::*;
#(
  parameter int unsigned BIN_LEN = DEF_BIN_LEN,
  parameter int unsigned BCD_LEN = DEF_BCD_LEN
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BIN_LEN-1:0] bin_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BCD_LEN-1:0] bcd_out,
  output logic               busy
);

  localparam int unsigned WORK_LEN = BIN_LEN + BCD_LEN;
  localparam int unsigned CNT_W    = $clog2(BIN_LEN + 1);

  if (BIN_LEN < 1 || (BCD_LEN % 4) != 0 ||
      (BCD_LEN / 4) < min_bcd_digits(BIN_LEN)) begin : g_bad_cfg
    $fatal(1, "bin2bcd_seq: BCD_LEN too small or not a multiple of 4 for BIN_LEN");
  end

  state_t              state, next_state;
  logic [CNT_W-1:0]    cnt;
  logic [WORK_LEN-1:0] work, work_step;
  logic                accept, last_step;

  dd_iter #(
    .BIN_LEN (BIN_LEN),
    .BCD_LEN (BCD_LEN)
  ) u_dd_iter (
    .work_in  (work),
    .work_out (work_step)
  );

  assign accept    = in_valid && in_ready;
  assign last_step = (cnt == CNT_W'(1));
  assign bcd_out   = work[WORK_LEN-1 -: BCD_LEN];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    unique case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) next_state = ST_SHIFT;
      end
      ST_SHIFT: begin
        busy = 1'b1;
        if (last_step) next_state = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Counter leaves SHIFT at 1, so it never underflows; it is only reloaded
  // on acceptance and held in DONE/IDLE, keeping bcd_out stable.
  always_ff @(posedge clk) begin
    if (rst) begin
      work <= '0;
      cnt  <= '0;
    end else if (accept) begin
      work <= {{BCD_LEN{1'b0}}, bin_in};
      cnt  <= CNT_W'(BIN_LEN);
    end else if (state == ST_SHIFT) begin
      work <= work_step;
      cnt  <= cnt - CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
module tb_bin2bcd_seq;

  localparam int unsigned BIN_LEN = 8;
  localparam int unsigned BCD_LEN = 12;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [BIN_LEN-1:0] bin_in = '0;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic [BCD_LEN-1:0] bcd_out;
  logic               busy;

  typedef struct {
    logic [BCD_LEN-1:0] exp;
    int                 acc;
  } txn_t;

  txn_t sb[$];
  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;
  int   bp_mode = 0;  // 0: out_ready high, 1: random, 2: held low

  bin2bcd_seq #(
    .BIN_LEN (BIN_LEN),
    .BCD_LEN (BCD_LEN)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .bin_in    (bin_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .bcd_out   (bcd_out),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Decimal reference: peel digits with /10 and %10.
  function automatic logic [BCD_LEN-1:0] to_bcd(input int v);
    logic [BCD_LEN-1:0] r;
    r = '0;
    for (int i = 0; i < int'(BCD_LEN / 4); i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic fail_bound(input string name);
    n_total++;
    $display("FAIL %s: bound expired, got timeout expected completion (t=%0t)", name, $time);
  endtask

  // Driver phase: always resumes at posedge + #1.
  task automatic send(input logic [BIN_LEN-1:0] v);
    int n;
    n = 0;
    in_valid = 1'b1;
    bin_in   = v;
    while (!in_ready && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      fail_bound("accept_wait");
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    sb.push_back('{to_bcd(int'(v)), cyc});
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    if (sb.size() != 0) fail_bound("drain_wait");
  endtask

  // out_ready generator
  initial begin
    forever begin
      @(posedge clk); #1;
      case (bp_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Monitor: expectations derived from the oldest outstanding transaction and
  // the number of edges elapsed since its acceptance.
  initial begin
    bit inflight;
    int e;
    forever begin
      @(negedge clk);
      inflight = (sb.size() != 0);
      e = inflight ? (cyc - sb[0].acc - 1) : 0;
      check("in_ready", 32'(in_ready), 32'(!inflight));
      check("busy", 32'(busy), 32'(inflight && e < int'(BIN_LEN)));
      check("out_valid", 32'(out_valid), 32'(inflight && e >= int'(BIN_LEN)));
      if (inflight && e >= int'(BIN_LEN)) begin
        check("bcd_out", 32'(bcd_out), 32'(sb[0].exp));
        if (out_ready) begin
          @(posedge clk);
          void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    #3000000;
    fail_bound("watchdog");
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    int perm[256];
    int j, tmp, n;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_bcd_out", 32'(bcd_out), 32'd0);

    bp_mode = 0;
    send(8'd255);
    wait_drain();
    send(8'd0);
    send(8'd99);
    send(8'd100);
    wait_drain();

    // Backpressure: hold out_ready low for 5 cycles of out_valid.
    bp_mode = 2;
    @(posedge clk); #1;
    send(8'd42);
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!out_valid) fail_bound("bp_out_valid_wait");
    repeat (5) begin
      @(posedge clk); #1;
    end
    check("bp_out_valid_held", 32'(out_valid), 32'd1);
    check("bp_bcd_held", 32'(bcd_out), 32'(to_bcd(42)));
    bp_mode = 0;
    wait_drain();
    check("bp_in_ready_after", 32'(in_ready), 32'd1);

    // in_valid pulsed while busy must be ignored.
    send(8'd200);
    in_valid = 1'b1;
    bin_in   = 8'd7;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_drain();

    // Reset during the third SHIFT cycle.
    send(8'd77);
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk);
    sb.delete();
    #1;
    rst = 1'b0;
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_bcd_out", 32'(bcd_out), 32'd0);
    send(8'd128);
    wait_drain();

    // All operands, shuffled, with random backpressure.
    bp_mode = 1;
    for (int i = 0; i < 256; i++) perm[i] = i;
    for (int i = 255; i > 0; i--) begin
      j = int'($urandom_range(0, i));
      tmp = perm[i];
      perm[i] = perm[j];
      perm[j] = tmp;
    end
    for (int i = 0; i < 256; i++) send(8'(perm[i]));
    wait_drain();

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
